// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : pipe_ctrl_pkg
// Brief   : Shared types for the pipeline stall/flush controller.
// Revision: 1.0
// ----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    localparam int c_DEFAULT_MEM_TIMEOUT = 16;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } ctrl_state_e;

    // Per-stage register controls, also consumed by the core top level.
    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_ex_write;
        logic ex_mem_write;
        logic if_id_flush;
        logic id_ex_flush;
        logic mem_wb_flush;
    } ctrl_vec_t;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : sat_counter
// Brief   : Up-counter that holds at all-ones; asynchronous active-low clear.
// Revision: 1.0
// ----------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipeline_stall_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : pipeline_stall_ctrl
// Brief   : Per-stage write-enable/flush control for the 5-stage pipeline.
// Revision: 1.0
// ----------------------------------------------------------------------------
module pipeline_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = c_DEFAULT_MEM_TIMEOUT,
    parameter int TO_W        = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             LU_hazard,
    input  logic             Branch_taken_EX,
    input  logic             Dmem_req,
    input  logic             Dmem_ready,
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic             ID_EX_write,
    output logic             EX_MEM_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic             MEM_WB_flush,
    output logic [CNT_W-1:0] Stall_cycles,
    output logic [CNT_W-1:0] Flush_count,
    output logic             Mem_err
);

    localparam logic [TO_W-1:0] c_WAIT_LAST = TO_W'(MEM_TIMEOUT - 1);

    ctrl_state_e     r_state;
    logic [TO_W-1:0] r_wait_cnt;
    logic            r_mem_err;

    logic      w_mem_busy;
    logic      w_frozen;
    logic      w_branch;
    logic      w_lu_stall;
    logic      w_stall_inc;
    logic      w_flush_inc;
    ctrl_vec_t w_ctrl;

    assign w_mem_busy  = Dmem_req & ~Dmem_ready;
    assign w_frozen    = (r_state != ERR) & w_mem_busy;
    assign w_branch    = (r_state != ERR) & ~w_mem_busy & Branch_taken_EX;
    assign w_lu_stall  = (r_state != ERR) & ~w_mem_busy & ~Branch_taken_EX & LU_hazard;
    assign w_stall_inc = w_frozen | w_lu_stall;
    assign w_flush_inc = w_branch;

    always_comb begin
        w_ctrl = '{pc_write: 1'b1, if_id_write: 1'b1, id_ex_write: 1'b1,
                   ex_mem_write: 1'b1, if_id_flush: 1'b0, id_ex_flush: 1'b0,
                   mem_wb_flush: 1'b0};
        if (!rst_n) begin
            w_ctrl = '{pc_write: 1'b0, if_id_write: 1'b0, id_ex_write: 1'b0,
                       ex_mem_write: 1'b0, if_id_flush: 1'b1, id_ex_flush: 1'b1,
                       mem_wb_flush: 1'b1};
        end else if ((r_state == ERR) || w_frozen) begin
            // Hold everything up to EX/MEM; MEM/WB drains a bubble.
            w_ctrl = '{pc_write: 1'b0, if_id_write: 1'b0, id_ex_write: 1'b0,
                       ex_mem_write: 1'b0, if_id_flush: 1'b0, id_ex_flush: 1'b0,
                       mem_wb_flush: 1'b1};
        end else if (w_branch) begin
            w_ctrl.if_id_flush = 1'b1;
            w_ctrl.id_ex_flush = 1'b1;
        end else if (w_lu_stall) begin
            w_ctrl.pc_write    = 1'b0;
            w_ctrl.if_id_write = 1'b0;
            w_ctrl.id_ex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_mem_busy) begin
                        // The busy cycle seen in RUN is the first counted wait.
                        if (MEM_TIMEOUT == 1) begin
                            r_state   <= ERR;
                            r_mem_err <= 1'b1;
                        end else begin
                            r_state <= WAIT;
                        end
                        r_wait_cnt <= TO_W'(1);
                    end else begin
                        r_wait_cnt <= '0;
                    end
                end
                WAIT: begin
                    if (!w_mem_busy) begin
                        r_state    <= RUN;
                        r_wait_cnt <= '0;
                    end else if (r_wait_cnt == c_WAIT_LAST) begin
                        r_state   <= ERR;
                        r_mem_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + TO_W'(1);
                    end
                end
                ERR: begin
                    r_state   <= ERR;
                    r_mem_err <= 1'b1;
                end
                default: begin
                    r_state    <= RUN;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_stall_inc),
        .count (Stall_cycles)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_flush_inc),
        .count (Flush_count)
    );

    assign PC_write     = w_ctrl.pc_write;
    assign IF_ID_write  = w_ctrl.if_id_write;
    assign ID_EX_write  = w_ctrl.id_ex_write;
    assign EX_MEM_write = w_ctrl.ex_mem_write;
    assign IF_ID_flush  = w_ctrl.if_id_flush;
    assign ID_EX_flush  = w_ctrl.id_ex_flush;
    assign MEM_WB_flush = w_ctrl.mem_wb_flush;
    assign Mem_err      = r_mem_err;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stall_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : tb_pipeline_stall_ctrl
// Brief   : Directed self-checking bench for pipeline_stall_ctrl.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_pipeline_stall_ctrl;

    localparam int CNT_W       = 4;
    localparam int MEM_TIMEOUT = 8;
    localparam int TO_W        = 5;

    // {PC, IF_ID_w, ID_EX_w, EX_MEM_w, IF_ID_f, ID_EX_f, MEM_WB_f}
    localparam logic [6:0] c_NORMAL = 7'b1111_000;
    localparam logic [6:0] c_RESET  = 7'b0000_111;
    localparam logic [6:0] c_FREEZE = 7'b0000_001;
    localparam logic [6:0] c_BRANCH = 7'b1111_110;
    localparam logic [6:0] c_LU     = 7'b0011_010;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             LU_hazard, Branch_taken_EX, Dmem_req, Dmem_ready;
    logic             PC_write, IF_ID_write, ID_EX_write, EX_MEM_write;
    logic             IF_ID_flush, ID_EX_flush, MEM_WB_flush;
    logic [CNT_W-1:0] Stall_cycles, Flush_count;
    logic             Mem_err;
    logic [6:0]       ctrl_obs;

    int total = 0;
    int bad   = 0;

    pipeline_stall_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(TO_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .LU_hazard       (LU_hazard),
        .Branch_taken_EX (Branch_taken_EX),
        .Dmem_req        (Dmem_req),
        .Dmem_ready      (Dmem_ready),
        .PC_write        (PC_write),
        .IF_ID_write     (IF_ID_write),
        .ID_EX_write     (ID_EX_write),
        .EX_MEM_write    (EX_MEM_write),
        .IF_ID_flush     (IF_ID_flush),
        .ID_EX_flush     (ID_EX_flush),
        .MEM_WB_flush    (MEM_WB_flush),
        .Stall_cycles    (Stall_cycles),
        .Flush_count     (Flush_count),
        .Mem_err         (Mem_err)
    );

    always #5 clk = ~clk;

    assign ctrl_obs = {PC_write, IF_ID_write, ID_EX_write, EX_MEM_write,
                       IF_ID_flush, ID_EX_flush, MEM_WB_flush};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; LU_hazard = 1'b0; Branch_taken_EX = 1'b0;
        Dmem_req = 1'b0; Dmem_ready = 1'b0;
        #2;
        total++; if (ctrl_obs !== c_RESET) begin bad++; $display("FAIL reset_ctrl got=%b want=%b", ctrl_obs, c_RESET); end
        total++; if (Stall_cycles !== 4'd0) begin bad++; $display("FAIL reset_stall got=%0d want=0", Stall_cycles); end
        total++; if (Flush_count !== 4'd0) begin bad++; $display("FAIL reset_flush got=%0d want=0", Flush_count); end
        total++; if (Mem_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", Mem_err); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_idle();
        #1;
        total++; if (ctrl_obs !== c_NORMAL) begin bad++; $display("FAIL idle_ctrl got=%b want=%b", ctrl_obs, c_NORMAL); end
        tick();
        total++; if (Stall_cycles !== 4'd0) begin bad++; $display("FAIL idle_stall got=%0d want=0", Stall_cycles); end
        total++; if (Flush_count !== 4'd0) begin bad++; $display("FAIL idle_flush got=%0d want=0", Flush_count); end
    endtask

    task automatic test_load_use();
        LU_hazard = 1'b1;
        #1;
        total++; if (ctrl_obs !== c_LU) begin bad++; $display("FAIL lu_ctrl got=%b want=%b", ctrl_obs, c_LU); end
        tick();
        LU_hazard = 1'b0;
        #1;
        total++; if (Stall_cycles !== 4'd1) begin bad++; $display("FAIL lu_stall got=%0d want=1", Stall_cycles); end
        total++; if (ctrl_obs !== c_NORMAL) begin bad++; $display("FAIL lu_after_ctrl got=%b want=%b", ctrl_obs, c_NORMAL); end
        tick();
        total++; if (Stall_cycles !== 4'd1) begin bad++; $display("FAIL lu_hold got=%0d want=1", Stall_cycles); end
    endtask

    task automatic test_branch_over_lu();
        LU_hazard = 1'b1; Branch_taken_EX = 1'b1;
        #1;
        total++; if (ctrl_obs !== c_BRANCH) begin bad++; $display("FAIL br_lu_ctrl got=%b want=%b", ctrl_obs, c_BRANCH); end
        tick();
        LU_hazard = 1'b0; Branch_taken_EX = 1'b0;
        #1;
        total++; if (Flush_count !== 4'd1) begin bad++; $display("FAIL br_lu_flush got=%0d want=1", Flush_count); end
        total++; if (Stall_cycles !== 4'd1) begin bad++; $display("FAIL br_lu_stall got=%0d want=1", Stall_cycles); end
    endtask

    task automatic test_freeze();
        Dmem_req = 1'b1; Dmem_ready = 1'b0; Branch_taken_EX = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (ctrl_obs !== c_FREEZE) begin bad++; $display("FAIL freeze_ctrl[%0d] got=%b want=%b", i, ctrl_obs, c_FREEZE); end
            tick();
        end
        Dmem_ready = 1'b1;
        #1;
        total++; if (ctrl_obs !== c_BRANCH) begin bad++; $display("FAIL release_ctrl got=%b want=%b", ctrl_obs, c_BRANCH); end
        tick();
        Dmem_req = 1'b0; Dmem_ready = 1'b0; Branch_taken_EX = 1'b0;
        #1;
        total++; if (Stall_cycles !== 4'd4) begin bad++; $display("FAIL freeze_stall got=%0d want=4", Stall_cycles); end
        total++; if (Flush_count !== 4'd2) begin bad++; $display("FAIL freeze_flush got=%0d want=2", Flush_count); end
        total++; if (ctrl_obs !== c_NORMAL) begin bad++; $display("FAIL freeze_after_ctrl got=%b want=%b", ctrl_obs, c_NORMAL); end
        tick();
        total++; if (Mem_err !== 1'b0) begin bad++; $display("FAIL freeze_err got=%b want=0", Mem_err); end
    endtask

    task automatic test_saturation();
        LU_hazard = 1'b1;
        repeat (12) tick();
        LU_hazard = 1'b0;
        #1;
        total++; if (Stall_cycles !== 4'd15) begin bad++; $display("FAIL sat_stall got=%0d want=15", Stall_cycles); end
        Branch_taken_EX = 1'b1;
        repeat (14) tick();
        Branch_taken_EX = 1'b0;
        #1;
        total++; if (Flush_count !== 4'd15) begin bad++; $display("FAIL sat_flush got=%0d want=15", Flush_count); end
        LU_hazard = 1'b1;
        tick();
        LU_hazard = 1'b0;
        total++; if (Stall_cycles !== 4'd15) begin bad++; $display("FAIL sat_stall_hold got=%0d want=15", Stall_cycles); end
    endtask

    task automatic test_back_to_back();
        pulse_reset();
        Dmem_req = 1'b1;
        for (int a = 0; a < 2; a++) begin
            Dmem_ready = 1'b0;
            repeat (6) tick();
            Dmem_ready = 1'b1;
            #1;
            total++; if (ctrl_obs !== c_NORMAL) begin bad++; $display("FAIL b2b_release[%0d] got=%b want=%b", a, ctrl_obs, c_NORMAL); end
            tick();
        end
        Dmem_req = 1'b0; Dmem_ready = 1'b0;
        total++; if (Mem_err !== 1'b0) begin bad++; $display("FAIL b2b_err got=%b want=0", Mem_err); end
        total++; if (Stall_cycles !== 4'd12) begin bad++; $display("FAIL b2b_stall got=%0d want=12", Stall_cycles); end
    endtask

    task automatic test_timeout();
        pulse_reset();
        Dmem_req = 1'b1; Dmem_ready = 1'b0;
        for (int k = 1; k <= MEM_TIMEOUT; k++) begin
            #1;
            total++; if (Mem_err !== 1'b0) begin bad++; $display("FAIL to_early_err[%0d] got=%b want=0", k, Mem_err); end
            tick();
        end
        total++; if (Mem_err !== 1'b1) begin bad++; $display("FAIL to_err got=%b want=1", Mem_err); end
        total++; if (ctrl_obs !== c_FREEZE) begin bad++; $display("FAIL to_err_ctrl got=%b want=%b", ctrl_obs, c_FREEZE); end
        Dmem_ready = 1'b1; LU_hazard = 1'b1; Branch_taken_EX = 1'b1;
        #1;
        total++; if (ctrl_obs !== c_FREEZE) begin bad++; $display("FAIL err_ignore_ctrl got=%b want=%b", ctrl_obs, c_FREEZE); end
        repeat (3) tick();
        total++; if (Mem_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b want=1", Mem_err); end
        total++; if (Flush_count !== 4'd0) begin bad++; $display("FAIL err_flush got=%0d want=0", Flush_count); end
        total++; if (Stall_cycles !== 4'd8) begin bad++; $display("FAIL err_stall got=%0d want=8", Stall_cycles); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (Mem_err !== 1'b0) begin bad++; $display("FAIL err_reset got=%b want=0", Mem_err); end
        total++; if (ctrl_obs !== c_RESET) begin bad++; $display("FAIL err_reset_ctrl got=%b want=%b", ctrl_obs, c_RESET); end
        Dmem_req = 1'b0; Dmem_ready = 1'b0; LU_hazard = 1'b0; Branch_taken_EX = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_async_reset();
        Branch_taken_EX = 1'b1;
        tick();
        Branch_taken_EX = 1'b0;
        Dmem_req = 1'b1; Dmem_ready = 1'b0;
        repeat (3) tick();
        total++; if (Stall_cycles !== 4'd3) begin bad++; $display("FAIL ar_pre_stall got=%0d want=3", Stall_cycles); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (ctrl_obs !== c_RESET) begin bad++; $display("FAIL ar_ctrl got=%b want=%b", ctrl_obs, c_RESET); end
        total++; if (Stall_cycles !== 4'd0) begin bad++; $display("FAIL ar_stall got=%0d want=0", Stall_cycles); end
        total++; if (Flush_count !== 4'd0) begin bad++; $display("FAIL ar_flush got=%0d want=0", Flush_count); end
        total++; if (Mem_err !== 1'b0) begin bad++; $display("FAIL ar_err got=%b want=0", Mem_err); end
        Dmem_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++; if (ctrl_obs !== c_NORMAL) begin bad++; $display("FAIL ar_post_ctrl got=%b want=%b", ctrl_obs, c_NORMAL); end
        Dmem_req = 1'b1;
        tick();
        Dmem_ready = 1'b1;
        #1;
        total++; if (ctrl_obs !== c_NORMAL) begin bad++; $display("FAIL ar_release_ctrl got=%b want=%b", ctrl_obs, c_NORMAL); end
        tick();
        Dmem_req = 1'b0; Dmem_ready = 1'b0;
        total++; if (Stall_cycles !== 4'd1) begin bad++; $display("FAIL ar_post_stall got=%0d want=1", Stall_cycles); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_idle();
        test_load_use();
        test_branch_over_lu();
        test_freeze();
        test_saturation();
        test_back_to_back();
        test_timeout();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
